// File: rtl/wbu_pkg.sv
// Shared core defines for the writeback unit: default widths, the x0 index
// and the commit source encoding used by the result arbiter.
package wbu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXU  = 2'd1,
        SRC_LSU  = 2'd2
    } commit_src_e;

endpackage

// File: rtl/wbu_if.sv
// Issue, hazard-query, result and register-file write signals of the
// writeback unit. The master side is the core around it; the slave side is wbu.
interface wbu_if
    import wbu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
);
    localparam int NREG = 2 ** RA_W;

    logic            iss_valid_i;
    logic [RA_W-1:0] iss_rd_i;
    logic            iss_ready_o;

    logic [RA_W-1:0] rs1_i;
    logic [RA_W-1:0] rs2_i;
    logic            rs1_busy_o;
    logic            rs2_busy_o;

    logic            exu_valid_i;
    logic            exu_ready_o;
    logic [RA_W-1:0] exu_rd_i;
    logic [XLEN-1:0] exu_data_i;

    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [RA_W-1:0] lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;

    logic            wen_o;
    logic [RA_W-1:0] rd_o;
    logic [XLEN-1:0] wdata_o;
    logic [NREG-1:0] busy_o;

    modport master (
        output iss_valid_i, iss_rd_i, rs1_i, rs2_i,
        output exu_valid_i, exu_rd_i, exu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  iss_ready_o, rs1_busy_o, rs2_busy_o,
        input  exu_ready_o, lsu_ready_o,
        input  wen_o, rd_o, wdata_o, busy_o
    );

    modport slave (
        input  iss_valid_i, iss_rd_i, rs1_i, rs2_i,
        input  exu_valid_i, exu_rd_i, exu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output iss_ready_o, rs1_busy_o, rs2_busy_o,
        output exu_ready_o, lsu_ready_o,
        output wen_o, rd_o, wdata_o, busy_o
    );

endinterface

// File: rtl/wbu_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register,
// with x0 never pending. Read ports see only the registered state.
module wbu_scoreboard
    import wbu_pkg::*;
#(
    parameter int RA_W = RA_W_DEF,
    parameter int NREG = 2 ** RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_en,
    input  logic [RA_W-1:0] set_rd,
    input  logic            clr_en,
    input  logic [RA_W-1:0] clr_rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] qry_rd,
    output logic [NREG-1:0] busy,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            qry_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a newly issued writer owns rd
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign qry_busy = busy_q[qry_rd];

endmodule

// File: rtl/wbu.sv
// Writeback unit: tracks outstanding register writes, arbitrates EXU and LSU
// results (LSU first) and drives a registered one-cycle register-file write.
module wbu
    import wbu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    wbu_if.slave bus
);

    localparam int              NREG    = 2 ** RA_W;
    localparam logic [RA_W-1:0] ZERO_RD = RA_W'(ZERO_REG);

    logic            iss_busy;
    logic            iss_fire;
    logic            exu_fire;
    logic            lsu_fire;
    commit_src_e     sel;
    logic [RA_W-1:0] cmt_rd;
    logic [XLEN-1:0] cmt_data;
    logic            cmt_valid;
    logic [NREG-1:0] busy;
    logic            rs1_busy;
    logic            rs2_busy;

    logic            wen_q;
    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] wdata_q;

    // Nothing is accepted while reset is held
    assign bus.lsu_ready_o = !rst_i;
    assign bus.exu_ready_o = !rst_i && !bus.lsu_valid_i;
    assign bus.iss_ready_o = !rst_i && (!iss_busy || (bus.iss_rd_i == ZERO_RD));

    assign iss_fire = bus.iss_valid_i && bus.iss_ready_o;
    assign exu_fire = bus.exu_valid_i && bus.exu_ready_o;
    assign lsu_fire = bus.lsu_valid_i && bus.lsu_ready_o;

    always_comb begin
        sel = SRC_NONE;
        if (lsu_fire) begin
            sel = SRC_LSU;
        end else if (exu_fire) begin
            sel = SRC_EXU;
        end
    end

    always_comb begin
        cmt_rd   = '0;
        cmt_data = '0;
        unique case (sel)
            SRC_LSU: begin
                cmt_rd   = bus.lsu_rd_i;
                cmt_data = bus.lsu_data_i;
            end
            SRC_EXU: begin
                cmt_rd   = bus.exu_rd_i;
                cmt_data = bus.exu_data_i;
            end
            default: begin
                cmt_rd   = '0;
                cmt_data = '0;
            end
        endcase
    end

    assign cmt_valid = (sel != SRC_NONE) && (cmt_rd != ZERO_RD);

    wbu_scoreboard #(
        .RA_W (RA_W),
        .NREG (NREG)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set_en   (iss_fire && (bus.iss_rd_i != ZERO_RD)),
        .set_rd   (bus.iss_rd_i),
        .clr_en   (cmt_valid),
        .clr_rd   (cmt_rd),
        .rs1      (bus.rs1_i),
        .rs2      (bus.rs2_i),
        .qry_rd   (bus.iss_rd_i),
        .busy     (busy),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .qry_busy (iss_busy)
    );

    // Write-port register; x0 results are accepted but never pulse wen
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wen_q   <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= cmt_valid;
            if (sel != SRC_NONE) begin
                rd_q    <= cmt_rd;
                wdata_q <= cmt_data;
            end
        end
    end

    assign bus.wen_o      = wen_q;
    assign bus.rd_o       = rd_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.busy_o     = busy;
    assign bus.rs1_busy_o = rs1_busy;
    assign bus.rs2_busy_o = rs2_busy;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: stimulus pushes expected register writes into a
// queue and a negedge monitor pops and compares them against the write port.
module tb_wbu;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
        int              due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    wbu_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    wbu #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [RA_W-1:0] ird,
                                 input logic ev, input logic [RA_W-1:0] erd, input logic [XLEN-1:0] edata,
                                 input logic lv, input logic [RA_W-1:0] lrd, input logic [XLEN-1:0] ldata);
        bus.iss_valid_i = iv;
        bus.iss_rd_i    = ird;
        bus.exu_valid_i = ev;
        bus.exu_rd_i    = erd;
        bus.exu_data_i  = edata;
        bus.lsu_valid_i = lv;
        bus.lsu_rd_i    = lrd;
        bus.lsu_data_i  = ldata;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expectWrite(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.due  = cycle_cnt + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: an expected write must appear exactly on its due cycle, otherwise wen must be low
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cycle_cnt) begin
            e = exp_q.pop_front();
            checkOutput("wen_pulse", 64'(bus.wen_o), 64'(1'b1));
            checkOutput("rd_o", 64'(bus.rd_o), 64'(e.rd));
            checkOutput("wdata_o", 64'(bus.wdata_o), 64'(e.data));
        end else begin
            checkOutput("wen_idle", 64'(bus.wen_o), 64'(1'b0));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.rs1_i = '0;
        bus.rs2_i = '0;
        // Reset with every valid asserted: nothing may be accepted
        applyStimulus(1, 5, 1, 5, 32'h1111, 1, 4, 32'h2222);
        tick();
        tick();
        checkOutput("rst_iss_ready", 64'(bus.iss_ready_o), 64'(1'b0));
        checkOutput("rst_exu_ready", 64'(bus.exu_ready_o), 64'(1'b0));
        checkOutput("rst_lsu_ready", 64'(bus.lsu_ready_o), 64'(1'b0));
        checkOutput("rst_busy", 64'(bus.busy_o), 64'h0);
        checkOutput("rst_wen", 64'(bus.wen_o), 64'(1'b0));
        checkOutput("rst_rd", 64'(bus.rd_o), 64'h0);
        checkOutput("rst_wdata", 64'(bus.wdata_o), 64'h0);
        rst = 1'b0;
        idle();
        tick();
        checkOutput("post_rst_busy", 64'(bus.busy_o), 64'h0);
        checkOutput("lsu_ready_run", 64'(bus.lsu_ready_o), 64'(1'b1));

        // Issue rd=5 then EXU result 0x1234; rs1 query has no same-cycle bypass
        bus.rs1_i = 5;
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("iss5_ready", 64'(bus.iss_ready_o), 64'(1'b1));
        checkOutput("rs1_no_bypass", 64'(bus.rs1_busy_o), 64'(1'b0));
        tick();
        idle();
        checkOutput("busy5_set", 64'(bus.busy_o), 64'h20);
        checkOutput("rs1_busy5", 64'(bus.rs1_busy_o), 64'(1'b1));
        tick();
        checkOutput("busy5_hold", 64'(bus.busy_o), 64'h20);
        applyStimulus(0, 0, 1, 5, 32'h1234, 0, 0, 0);
        checkOutput("exu_ready_alone", 64'(bus.exu_ready_o), 64'(1'b1));
        expectWrite(5, 32'h1234);
        tick();
        idle();
        checkOutput("busy5_clr", 64'(bus.busy_o), 64'h0);

        // EXU and LSU together: LSU first, EXU back-to-back after
        applyStimulus(0, 0, 1, 3, 32'hAAAA, 1, 4, 32'h5555);
        checkOutput("exu_blocked", 64'(bus.exu_ready_o), 64'(1'b0));
        checkOutput("lsu_ready", 64'(bus.lsu_ready_o), 64'(1'b1));
        expectWrite(4, 32'h5555);
        tick();
        applyStimulus(0, 0, 1, 3, 32'hAAAA, 0, 0, 0);
        checkOutput("exu_unblocked", 64'(bus.exu_ready_o), 64'(1'b1));
        expectWrite(3, 32'hAAAA);
        tick();
        idle();

        // WAW stall on rd=7, released in the cycle its busy bit clears
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("iss7_ready", 64'(bus.iss_ready_o), 64'(1'b1));
        tick();
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("iss7_stall", 64'(bus.iss_ready_o), 64'(1'b0));
        checkOutput("busy7_set", 64'(bus.busy_o), 64'h80);
        tick();
        checkOutput("busy7_stalled", 64'(bus.busy_o), 64'h80);
        applyStimulus(1, 7, 1, 7, 32'h77, 0, 0, 0);
        checkOutput("iss7_stall_commit", 64'(bus.iss_ready_o), 64'(1'b0));
        expectWrite(7, 32'h77);
        tick();
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("busy7_clr", 64'(bus.busy_o), 64'h0);
        checkOutput("iss7_release", 64'(bus.iss_ready_o), 64'(1'b1));
        tick();
        idle();
        checkOutput("busy7_reissued", 64'(bus.busy_o), 64'h80);

        // Source queries
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
        tick();
        bus.rs1_i = 9;
        bus.rs2_i = 0;
        idle();
        checkOutput("busy_7_9", 64'(bus.busy_o), 64'h280);
        checkOutput("rs1_busy9", 64'(bus.rs1_busy_o), 64'(1'b1));
        checkOutput("rs2_busy0", 64'(bus.rs2_busy_o), 64'(1'b0));

        // x0: result accepted with no write, issue to x0 always ready
        applyStimulus(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        checkOutput("iss0_ready", 64'(bus.iss_ready_o), 64'(1'b1));
        checkOutput("exu0_ready", 64'(bus.exu_ready_o), 64'(1'b1));
        tick();
        idle();
        checkOutput("busy_after_x0", 64'(bus.busy_o), 64'h280);

        // Result for a non-busy register still writes
        applyStimulus(0, 0, 1, 12, 32'hC0DE, 0, 0, 0);
        expectWrite(12, 32'hC0DE);
        tick();
        idle();
        checkOutput("busy_nonbusy_wr", 64'(bus.busy_o), 64'h280);

        // Same-edge issue and commit on rd=12: issue wins
        applyStimulus(1, 12, 1, 12, 32'hBEEF, 0, 0, 0);
        checkOutput("iss12_ready", 64'(bus.iss_ready_o), 64'(1'b1));
        expectWrite(12, 32'hBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h0707);
        checkOutput("busy_set_wins", 64'(bus.busy_o), 64'h1280);
        expectWrite(7, 32'h0707);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h0909);
        expectWrite(9, 32'h0909);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 12, 32'h0C0C);
        expectWrite(12, 32'h0C0C);
        tick();
        idle();
        checkOutput("busy_drained", 64'(bus.busy_o), 64'h0);

        // Reset one cycle after a result handshake
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 5, 32'h55AA, 0, 0, 0);
        checkOutput("busy_5_6", 64'(bus.busy_o), 64'h60);
        expectWrite(5, 32'h55AA);
        tick();
        rst = 1'b1;
        applyStimulus(1, 8, 1, 3, 32'h3333, 1, 2, 32'h2222);
        checkOutput("mid_rst_iss_ready", 64'(bus.iss_ready_o), 64'(1'b0));
        checkOutput("mid_rst_exu_ready", 64'(bus.exu_ready_o), 64'(1'b0));
        checkOutput("mid_rst_lsu_ready", 64'(bus.lsu_ready_o), 64'(1'b0));
        tick();
        checkOutput("mid_rst_busy", 64'(bus.busy_o), 64'h0);
        checkOutput("mid_rst_wen", 64'(bus.wen_o), 64'(1'b0));
        checkOutput("mid_rst_rd", 64'(bus.rd_o), 64'h0);
        checkOutput("mid_rst_wdata", 64'(bus.wdata_o), 64'h0);
        rst = 1'b0;
        idle();
        tick();
        checkOutput("post_mid_rst_busy", 64'(bus.busy_o), 64'h0);

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            tick();
        end
        checkOutput("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
